// File: rtl/stream_trailing_zeroes.sv
// stream_trailing_zeroes
// Counts the trailing zeroes of a frame of 1..MAX_WORDS words, least significant word first.
// One result is produced per frame and held until the consumer accepts it.
//
// Ports:
//   clk            clock; all state updates on its rising edge
//   reset          synchronous, active-high reset
//   din            frame word, bit 0 least significant
//   din_valid      din/din_last valid this cycle
//   din_last       final word of the frame
//   din_ready      block accepts a word this cycle (ACCUM state)
//   dout           trailing-zero count of the frame
//   dout_all_zero  no set bit in the whole frame
//   dout_trunc     frame ended at MAX_WORDS without din_last
//   dout_valid     result outputs valid (HOLD state)
//   dout_ready     consumer accepts the result
module stream_trailing_zeroes #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 8,
  localparam int unsigned CNT_W     = $clog2(DATA_WIDTH * MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [CNT_W-1:0]      dout,
  output logic                  dout_all_zero,
  output logic                  dout_trunc,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] dout_q;
  logic             all_zero_q;
  logic             trunc_q;

  logic             accept;
  logic             frame_end;
  logic             full;

  // Index of the lowest set bit; only meaningful for a nonzero word.
  function automatic logic [CNT_W-1:0] lsb_index(input logic [DATA_WIDTH-1:0] w);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (w[i]) idx = CNT_W'(i);
    end
    return idx;
  endfunction

  assign din_ready     = (state_q == StAccum);
  assign dout_valid    = (state_q == StHold);
  assign dout          = dout_q;
  assign dout_all_zero = all_zero_q;
  assign dout_trunc    = trunc_q;

  assign accept = din_valid && (state_q == StAccum);

  always_comb begin
    cnt_d   = cnt_q;
    found_d = found_q;
    wcnt_d  = wcnt_q + WC_W'(1);
    // Count only grows until the first set bit; later words leave it alone.
    if (!found_q) begin
      if (din == '0) begin
        cnt_d = cnt_q + CNT_W'(DATA_WIDTH);
      end else begin
        cnt_d   = cnt_q + lsb_index(din);
        found_d = 1'b1;
      end
    end
    full      = (wcnt_d == WC_W'(MAX_WORDS));
    frame_end = din_last || full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAccum;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      wcnt_q     <= '0;
      dout_q     <= '0;
      all_zero_q <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            if (frame_end) begin
              dout_q     <= cnt_d;
              all_zero_q <= !found_d;
              trunc_q    <= full && !din_last;
              state_q    <= StHold;
            end
            cnt_q   <= cnt_d;
            found_q <= found_d;
            wcnt_q  <= wcnt_d;
          end
        end
        StHold: begin
          if (dout_ready) begin
            cnt_q   <= '0;
            found_q <= 1'b0;
            wcnt_q  <= '0;
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_trailing_zeroes.sv
module tb_stream_trailing_zeroes;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned MaxWords  = 4;
  localparam int unsigned CntW      = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      din;
  logic            din_valid;
  logic            din_last;
  logic            din_ready;
  logic [CntW-1:0] dout;
  logic            dout_all_zero;
  logic            dout_trunc;
  logic            dout_valid;
  logic            dout_ready;

  int n_checks = 0;
  int n_errors = 0;

  stream_trailing_zeroes #(
    .DATA_WIDTH(DataWidth),
    .MAX_WORDS (MaxWords)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .din_valid    (din_valid),
    .din_last     (din_last),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_all_zero(dout_all_zero),
    .dout_trunc   (dout_trunc),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one word for one clock; the block must be ready to take it.
  task automatic send_word(input string tag, input logic [7:0] data, input logic last);
    check_eq({tag, " din_ready"}, 32'(din_ready), 32'd1);
    din       = data;
    din_last  = last;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int cnt, input logic az, input logic tr);
    check_eq({tag, " dout_valid"}, 32'(dout_valid), 32'd1);
    check_eq({tag, " din_ready"}, 32'(din_ready), 32'd0);
    check_eq({tag, " dout"}, 32'(dout), 32'(cnt));
    check_eq({tag, " all_zero"}, 32'(dout_all_zero), 32'(az));
    check_eq({tag, " trunc"}, 32'(dout_trunc), 32'(tr));
  endtask

  task automatic handshake(input string tag);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    check_eq({tag, " valid after hs"}, 32'(dout_valid), 32'd0);
    check_eq({tag, " ready after hs"}, 32'(din_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst dout_valid", 32'(dout_valid), 32'd0);
    check_eq("rst din_ready", 32'(din_ready), 32'd1);
    check_eq("rst dout", 32'(dout), 32'd0);
    check_eq("rst all_zero", 32'(dout_all_zero), 32'd0);
    check_eq("rst trunc", 32'(dout_trunc), 32'd0);

    // Single word 0x10 -> 4
    send_word("single", 8'h10, 1'b1);
    expect_result("single", 4, 1'b0, 1'b0);
    handshake("single");

    // 00 00 04(last) -> 18
    send_word("three", 8'h00, 1'b0);
    send_word("three", 8'h00, 1'b0);
    send_word("three", 8'h04, 1'b1);
    expect_result("three", 18, 1'b0, 1'b0);
    handshake("three");

    // 00 00 04 FF(last on 4th word) -> 18, not truncated
    send_word("four_last", 8'h00, 1'b0);
    send_word("four_last", 8'h00, 1'b0);
    send_word("four_last", 8'h04, 1'b0);
    send_word("four_last", 8'hFF, 1'b1);
    expect_result("four_last", 18, 1'b0, 1'b0);
    handshake("four_last");

    // 00 00(last) -> 16, all zero
    send_word("zeros2", 8'h00, 1'b0);
    send_word("zeros2", 8'h00, 1'b1);
    expect_result("zeros2", 16, 1'b1, 1'b0);
    handshake("zeros2");

    // 00 01 00 00 no last -> 8, truncated
    send_word("trunc", 8'h00, 1'b0);
    send_word("trunc", 8'h01, 1'b0);
    send_word("trunc", 8'h00, 1'b0);
    send_word("trunc", 8'h00, 1'b0);
    expect_result("trunc", 8, 1'b0, 1'b1);

    // Stall the consumer 3 cycles while offering words that must be ignored
    din       = 8'h01;
    din_last  = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_result("stall", 8, 1'b0, 1'b1);
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    handshake("stall");
    send_word("after_stall", 8'h80, 1'b1);
    expect_result("after_stall", 7, 1'b0, 1'b0);
    handshake("after_stall");

    // Full all-zero frame with no last -> maximum count
    for (int i = 0; i < 4; i++) send_word("max", 8'h00, 1'b0);
    expect_result("max", 32, 1'b1, 1'b1);
    handshake("max");

    // Reset mid-frame discards the partial frame
    send_word("midrst", 8'h00, 1'b0);
    send_word("midrst", 8'h00, 1'b0);
    do_reset();
    send_word("midrst", 8'h02, 1'b1);
    expect_result("midrst", 1, 1'b0, 1'b0);

    // Reset in HOLD drops the pending result
    do_reset();
    check_eq("holdrst dout_valid", 32'(dout_valid), 32'd0);
    check_eq("holdrst din_ready", 32'(din_ready), 32'd1);
    check_eq("holdrst dout", 32'(dout), 32'd0);
    send_word("holdrst", 8'h08, 1'b1);
    expect_result("holdrst", 3, 1'b0, 1'b0);
    handshake("holdrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
